// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//
// Multi-port register file with an integrated busy scoreboard.
// - Reads are combinational. Address 0 always reads as zero.
// - Writes are byte-masked. A write clears the busy bit of its register.
// - A reservation sets the busy bit of its register.
//   If a reservation and a write hit the same register on the same edge,
//   the data is written and the register stays busy.
// - pend_cnt_o is a registered count of busy registers.
//
// Optional feature:
//   Macro REG_FILE_SB_BYPASS_EN enables same-cycle write-to-read forwarding.
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_ni       asynchronous active-low reset (clears data, busy and count)
//   raddr_i      NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata_o      NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   rbusy_o      busy flag of the register addressed by each read port
//   we_i         writeback enable
//   waddr_i      writeback address
//   wdata_i      writeback data
//   wbe_i        writeback byte enables
//   resv_i       reserve a destination register
//   resv_addr_i  register to reserve
//   busy_o       scoreboard busy vector (bit 0 is always 0)
//   pend_cnt_o   number of busy registers
// ---------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        rbusy_o,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [DATA_W/8-1:0]      wbe_i,
  input  logic                     resv_i,
  input  logic [ADDR_W-1:0]        resv_addr_i,
  output logic [NUM_REGS-1:0]      busy_o,
  output logic [ADDR_W:0]          pend_cnt_o
);

  localparam int NB = DATA_W / 8;

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W:0]     pend_cnt;

  logic wr_ok;
  logic resv_ok;
  logic cnt_inc;
  logic cnt_dec;

  assign wr_ok   = we_i   && (waddr_i     != '0);
  assign resv_ok = resv_i && (resv_addr_i != '0);

  // The count rises only when a clear register becomes busy.
  // The count falls only when a busy register is released and not re-reserved on the same edge.
  assign cnt_inc = resv_ok && !busy[resv_addr_i];
  assign cnt_dec = wr_ok && busy[waddr_i] && !(resv_ok && (resv_addr_i == waddr_i));

  // The set is applied after the clear, so a reservation wins a same-address collision.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)   busy_nxt[waddr_i]     = 1'b0;
    if (resv_ok) busy_nxt[resv_addr_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= pend_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr_i] <= byte_merge(regs[waddr_i], wdata_i, wbe_i);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;

    assign ra     = raddr_i[k*ADDR_W +: ADDR_W];
    assign stored = (ra == '0) ? '0 : regs[ra];

`ifdef REG_FILE_SB_BYPASS_EN
    logic hit;
    assign hit = wr_ok && (ra == waddr_i);
    assign rdata_o[k*DATA_W +: DATA_W] = hit ? byte_merge(stored, wdata_i, wbe_i) : stored;
    // The write in flight releases the register; only a same-cycle reservation keeps it busy.
    assign rbusy_o[k] = hit ? (resv_ok && (resv_addr_i == ra)) : busy[ra];
`else
    assign rdata_o[k*DATA_W +: DATA_W] = stored;
    assign rbusy_o[k] = busy[ra];
`endif
  end

  assign busy_o     = busy;
  assign pend_cnt_o = pend_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_RD   = 2;
  localparam int ADDR_W   = 5;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [NUM_RD*ADDR_W-1:0] raddr_i;
  logic [NUM_RD*DATA_W-1:0] rdata_o;
  logic [NUM_RD-1:0]        rbusy_o;
  logic                     we_i;
  logic [ADDR_W-1:0]        waddr_i;
  logic [DATA_W-1:0]        wdata_i;
  logic [DATA_W/8-1:0]      wbe_i;
  logic                     resv_i;
  logic [ADDR_W-1:0]        resv_addr_i;
  logic [NUM_REGS-1:0]      busy_o;
  logic [ADDR_W:0]          pend_cnt_o;

  reg_file_sb #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .rbusy_o(rbusy_o), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .wbe_i(wbe_i), .resv_i(resv_i), .resv_addr_i(resv_addr_i),
    .busy_o(busy_o), .pend_cnt_o(pend_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model
  logic [DATA_W-1:0]   m_regs [NUM_REGS];
  logic [NUM_REGS-1:0] m_busy;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] data;
    logic              busy;
  } exp_t;
  exp_t exp_q[$];

  logic [DATA_W-1:0] obs_data [NUM_RD];
  logic              obs_busy [NUM_RD];

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] n,
                                              input logic [3:0] be);
    logic [DATA_W-1:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_busy = '0;
  endfunction

  // Called at posedge+1: drive one cycle, check reads at negedge, check state after the edge.
  task automatic do_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [3:0] be, input logic rv, input logic [4:0] ra_v,
                          input logic [4:0] rd0, input logic [4:0] rd1);
    logic [4:0] rd [2];
    exp_t e;
    we_i = we; waddr_i = wa; wdata_i = wd; wbe_i = be;
    resv_i = rv; resv_addr_i = ra_v;
    raddr_i = {rd1, rd0};
    rd[0] = rd0; rd[1] = rd1;
    for (int k = 0; k < NUM_RD; k++) begin
      e.tag = $sformatf("rd%0d_x%0d", k, rd[k]);
      if (rd[k] == 0) begin
        e.data = '0; e.busy = 1'b0;
      end else begin
        e.data = m_regs[rd[k]];
        e.busy = m_busy[rd[k]];
`ifdef REG_FILE_SB_BYPASS_EN
        if (we && wa == rd[k]) begin
          e.data = merge(m_regs[rd[k]], wd, be);
          e.busy = rv && (ra_v == rd[k]);
        end
`endif
      end
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    for (int k = 0; k < NUM_RD; k++) begin
      e = exp_q.pop_front();
      obs_data[k] = rdata_o[k*DATA_W +: DATA_W];
      obs_busy[k] = rbusy_o[k];
      check_val({e.tag, "_data"}, 64'(obs_data[k]), 64'(e.data));
      check_val({e.tag, "_busy"}, 64'(obs_busy[k]), 64'(e.busy));
    end
    @(posedge clk_i);
    if (we && wa != 0) begin
      m_regs[wa] = merge(m_regs[wa], wd, be);
      m_busy[wa] = 1'b0;
    end
    if (rv && ra_v != 0) m_busy[ra_v] = 1'b1;
    #1;
    check_val("busy_vec", 64'(busy_o), 64'(m_busy));
    check_val("pend_cnt", 64'(pend_cnt_o), 64'($countones(m_busy)));
  endtask

  task automatic idle(input logic [4:0] rd0, input logic [4:0] rd1);
    do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, rd0, rd1);
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    we_i = 1'b0; resv_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    we_i = 1'b0; waddr_i = '0; wdata_i = '0; wbe_i = '0;
    resv_i = 1'b0; resv_addr_i = '0; raddr_i = {5'd2, 5'd1};
    model_reset();
    #3;
    check_val("rst_busy", 64'(busy_o), 64'h0);
    check_val("rst_cnt", 64'(pend_cnt_o), 64'h0);
    check_val("rst_rdata", 64'(rdata_o), 64'h0);
    release_reset();

    // Byte-masked write
    do_cycle(1'b1, 5'd5, 32'h11223344, 4'hF, 1'b0, 5'd0, 5'd5, 5'd0);
    do_cycle(1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0, 5'd5, 5'd5);
    idle(5'd5, 5'd0);
    check_val("byte_x5", 64'(obs_data[0]), 64'h11BB33DD);

    // Reservation sequence x3, x7, x3, then release x7
    do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd7);
    check_val("cnt_after_x3", 64'(pend_cnt_o), 64'd1);
    do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7, 5'd3, 5'd7);
    check_val("cnt_after_x7", 64'(pend_cnt_o), 64'd2);
    do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd7);
    check_val("cnt_after_x3b", 64'(pend_cnt_o), 64'd2);
    do_cycle(1'b1, 5'd7, 32'h77, 4'hF, 1'b0, 5'd0, 5'd3, 5'd7);
    check_val("busy7_clr", 64'(busy_o[7]), 64'd0);
    check_val("cnt_after_wr7", 64'(pend_cnt_o), 64'd1);

    // Collision on a clear register: count goes up
    do_cycle(1'b1, 5'd9, 32'hCAFE, 4'hF, 1'b1, 5'd9, 5'd9, 5'd3);
    check_val("coll_busy9", 64'(busy_o[9]), 64'd1);
    check_val("coll_cnt", 64'(pend_cnt_o), 64'd2);
    idle(5'd9, 5'd9);
    check_val("coll_x9", 64'(obs_data[0]), 64'hCAFE);
    // Collision on an already-busy register: count unchanged
    do_cycle(1'b1, 5'd3, 32'h3333, 4'hF, 1'b1, 5'd3, 5'd3, 5'd9);
    check_val("coll_busy3_cnt", 64'(pend_cnt_o), 64'd2);

    // Register 0 ignores writes and reservations
    do_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 5'd0, 5'd0);
    check_val("x0_busy", 64'(busy_o[0]), 64'd0);
    check_val("x0_cnt", 64'(pend_cnt_o), 64'd2);
    idle(5'd0, 5'd0);
    check_val("x0_rd0", 64'(obs_data[0]), 64'd0);
    check_val("x0_rd1", 64'(obs_data[1]), 64'd0);

    // Forwarding behaviour on x4 (stored 0, busy)
    do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd4, 5'd0, 5'd4);
    do_cycle(1'b1, 5'd4, 32'h55, 4'hF, 1'b0, 5'd0, 5'd0, 5'd4);
`ifdef REG_FILE_SB_BYPASS_EN
    check_val("byp_rdata", 64'(obs_data[1]), 64'h55);
    check_val("byp_rbusy", 64'(obs_busy[1]), 64'd0);
`else
    check_val("byp_rdata", 64'(obs_data[1]), 64'h0);
    check_val("byp_rbusy", 64'(obs_busy[1]), 64'd1);
`endif
    idle(5'd4, 5'd4);
    check_val("x4_after", 64'(obs_data[0]), 64'h55);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Reset mid-run with exactly five busy registers
    rst_ni = 1'b0;
    #1;
    model_reset();
    release_reset();
    for (int r = 11; r < 16; r++)
      do_cycle(1'b1, 5'(r), 32'h1000 + r, 4'hF, 1'b1, 5'(r), 5'(r), 5'd5);
    check_val("five_busy", 64'(pend_cnt_o), 64'd5);
    #2;
    raddr_i = {5'd12, 5'd11};
    we_i = 1'b1; waddr_i = 5'd13; wdata_i = 32'hDEAD; wbe_i = 4'hF;
    resv_i = 1'b1; resv_addr_i = 5'd20;
    rst_ni = 1'b0;
    #1;
    check_val("midrst_rdata", 64'(rdata_o), 64'h0);
    check_val("midrst_busy", 64'(busy_o), 64'h0);
    check_val("midrst_cnt", 64'(pend_cnt_o), 64'h0);
    @(posedge clk_i);
    #1;
    check_val("rst_hold_busy", 64'(busy_o), 64'h0);
    check_val("rst_hold_cnt", 64'(pend_cnt_o), 64'h0);
    model_reset();
    release_reset();
    idle(5'd13, 5'd20);
    do_cycle(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd20, 5'd13, 5'd20);
    check_val("post_rst_cnt", 64'(pend_cnt_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
